// File: rtl/instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module : instr_fetch_unit
// Brief  : PC register driving a combinational ROM, plus a small fetch FIFO
//          with valid/ready output to decode and redirect-with-flush support.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus4
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);
    localparam logic [c_CNT_W-1:0] c_DEPTH_CNT = c_CNT_W'(DEPTH);

    logic [31:0]        r_pc;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [31:0]        r_pc_mem    [DEPTH];
    logic [31:0]        r_instr_mem [DEPTH];

    logic w_deq;
    logic w_fetch_en;

    assign instr_addr = r_pc;
    assign if_valid   = (r_count != '0);
    assign w_deq      = if_valid && if_ready;
    // A full buffer that is draining this cycle can still accept, so streaming
    // never inserts a bubble.
    assign w_fetch_en = (r_count < c_DEPTH_CNT) || w_deq;

    assign if_instr    = if_valid ? r_instr_mem[r_rd_ptr] : 32'h0;
    assign if_pc       = if_valid ? r_pc_mem[r_rd_ptr]    : 32'h0;
    assign if_pc_plus4 = if_valid ? (r_pc_mem[r_rd_ptr] + 32'd4) : 32'h0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pc     <= RESET_PC;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_pc_mem[i]    <= 32'h0;
                r_instr_mem[i] <= 32'h0;
            end
        end else if (redirect_valid) begin
            // Any head transfer this cycle has already been taken by decode.
            r_pc     <= {redirect_target[31:2], 2'b00};
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_fetch_en) begin
                r_pc_mem[r_wr_ptr]    <= r_pc;
                r_instr_mem[r_wr_ptr] <= instr_data;
                r_wr_ptr              <= r_wr_ptr + 1'b1;
                r_pc                  <= r_pc + 32'd4;
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_fetch_en, w_deq})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
//------------------------------------------------------------------------------
// Module : tb_instr_fetch_unit
// Brief  : Directed vector bench for instr_fetch_unit with a modelled ROM.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk;
    logic        reset_n;
    logic [31:0] instr_addr;
    logic [31:0] instr_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .DEPTH    (2)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .instr_addr      (instr_addr),
        .instr_data      (instr_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] rom(input logic [31:0] a);
        return 32'h1000_0000 + (a >> 2);
    endfunction

    assign instr_data = rom(instr_addr);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_out(input string tag, input bit v, input logic [31:0] pc,
                             input logic [31:0] addr);
        check({tag, " valid"}, {31'h0, if_valid}, {31'h0, v});
        check({tag, " addr"}, instr_addr, addr);
        check({tag, " pc"}, if_pc, v ? pc : 32'h0);
        check({tag, " instr"}, if_instr, v ? rom(pc) : 32'h0);
        check({tag, " pc_plus4"}, if_pc_plus4, v ? pc + 32'd4 : 32'h0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        bit          ready;
        bit          redir;
        logic [31:0] tgt;
        bit          exp_v;
        logic [31:0] exp_pc;
        logic [31:0] exp_addr;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // ready, redirect, target | expected valid, if_pc, instr_addr
        vecs[0]  = '{1, 0, 32'h0,         0, 32'h0,         32'h0};
        vecs[1]  = '{1, 0, 32'h0,         1, 32'h0,         32'h4};
        vecs[2]  = '{1, 0, 32'h0,         1, 32'h4,         32'h8};
        vecs[3]  = '{1, 0, 32'h0,         1, 32'h8,         32'hC};
        vecs[4]  = '{1, 1, 32'h40,        1, 32'hC,         32'h10};
        vecs[5]  = '{1, 0, 32'h0,         0, 32'h0,         32'h40};
        vecs[6]  = '{1, 0, 32'h0,         1, 32'h40,        32'h44};
        vecs[7]  = '{0, 0, 32'h0,         1, 32'h44,        32'h48};
        vecs[8]  = '{0, 0, 32'h0,         1, 32'h44,        32'h4C};
        vecs[9]  = '{0, 0, 32'h0,         1, 32'h44,        32'h4C};
        vecs[10] = '{1, 0, 32'h0,         1, 32'h44,        32'h4C};
        vecs[11] = '{1, 1, 32'h47,        1, 32'h48,        32'h50};
        vecs[12] = '{1, 0, 32'h0,         0, 32'h0,         32'h44};
        vecs[13] = '{1, 1, 32'hFFFF_FFFC, 1, 32'h44,        32'h48};
        vecs[14] = '{1, 0, 32'h0,         0, 32'h0,         32'hFFFF_FFFC};
        vecs[15] = '{1, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h0};
        vecs[16] = '{1, 0, 32'h0,         1, 32'h0,         32'h4};
        vecs[17] = '{0, 0, 32'h0,         1, 32'h4,         32'h8};
        vecs[18] = '{0, 0, 32'h0,         1, 32'h4,         32'hC};

        reset_n         = 1'b0;
        if_ready        = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        repeat (2) step();
        check_out("reset", 0, 32'h0, 32'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            if_ready        = vecs[i].ready;
            redirect_valid  = vecs[i].redir;
            redirect_target = vecs[i].tgt;
            check_out($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_pc, vecs[i].exp_addr);
            step();
        end
        redirect_valid = 1'b0;

        // Buffer is full here; pull reset between edges and expect immediate effect.
        check_out("full_before_reset", 1, 32'h4, 32'hC);
        #2;
        reset_n = 1'b0;
        #1;
        check_out("async_reset", 0, 32'h0, 32'h0);
        #3;
        reset_n = 1'b1;
        step();

        // Backpressure from reset: two entries buffered, then drain with no bubble.
        repeat (4) step();
        check_out("bp_hold", 1, 32'h0, 32'h8);
        if_ready = 1'b1;
        check_out("bp_drain0", 1, 32'h0, 32'h8);
        step();
        check_out("bp_drain1", 1, 32'h4, 32'hC);
        step();
        check_out("bp_drain2", 1, 32'h8, 32'h10);

        // Back-to-back redirects: the later target wins.
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        step();
        redirect_target = 32'h200;
        step();
        redirect_valid = 1'b0;
        check_out("b2b_flush", 0, 32'h0, 32'h200);
        step();
        check_out("b2b_first", 1, 32'h200, 32'h204);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the combinational instruction ROM and drives its byte address every cycle.
- Holds the program counter and captures each {pc, instruction} returned by the ROM into a small FIFO.
- Presents fetched instructions to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) with flush of all buffered instructions.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.
- DEPTH, 2, fetch buffer entries; power of two, 2..8.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- instr_addr  output  32  byte address to ROM addr; always equals the PC register.
- instr_data  input  32  ROM data for instr_addr, valid in the same cycle (combinational).
- redirect_valid  input  1  load a new PC and flush the buffer.
- redirect_target  input  32  new PC; bits [1:0] are ignored and treated as 0.
- if_valid  output  1  buffer head holds an instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction.
- if_pc  output  32  head instruction address.
- if_pc_plus4  output  32  if_pc + 4, modulo 2^32.

Behaviour:
- Reset (async assert, sync use after deassert):
  - pc = RESET_PC; buffer empty; read/write pointers and count = 0.
  - if_valid = 0; if_instr, if_pc, if_pc_plus4 = 0 while empty.
- instr_addr = pc, always. The ROM returns instr_data in the same cycle.
- Handshake: deq = if_valid && if_ready.
- Fetch enable: fetch_en = (count < DEPTH) || deq.
  - A full buffer with a simultaneous dequeue still fetches, so there is no bubble.
- Normal cycle (redirect_valid = 0):
  - If fetch_en: write {pc, instr_data} at wr_ptr, wr_ptr++, pc <= pc + 4 (wraps 32'hFFFF_FFFC -> 0).
  - If not fetch_en: pc holds, nothing written.
  - If deq: rd_ptr++.
  - count updates by +fetch_en − deq.
  - Pointers wrap modulo DEPTH.
- Redirect cycle (redirect_valid = 1, highest priority):
  - pc <= {redirect_target[31:2], 2'b00}.
  - count, wr_ptr and rd_ptr <= 0.
  - instr_data this cycle is discarded, and no entry is written.
  - A deq in the same cycle counts as a completed transfer; decode owns that instruction.
  - Next cycle: if_valid = 0, instr_addr = target.
  - Following cycle: if_valid = 1 with if_pc = target.
  - Redirect-to-output latency is 2 cycles.
- Latency: an instruction fetched in cycle N is visible at the outputs in cycle N+1. The first valid after reset release appears 1 cycle after the first active clk edge.
- Output stability: if if_valid = 1 and if_ready = 0, then if_instr, if_pc and if_pc_plus4 hold unchanged until deq or redirect.
- Back-to-back redirects: the last one wins; each flushes.
- Empty buffer with if_ready = 1: no dequeue, pointers unchanged.
- Outputs are driven from buffer registers; there is no combinational path from instr_data to the if_* outputs.
- reset_n asserted mid-stream: everything returns to reset values immediately, without waiting for clk.
- Throughput: 1 instruction/cycle when if_ready is held at 1.

Test Plan:
- Reset + streaming: RESET_PC = 0, ROM word[k] = 32'h1000_0000 + k, if_ready = 1 → from cycle 1, one instruction per cycle: (if_pc, if_instr) = (0, 32'h1000_0000), (4, 32'h1000_0001), (8, 32'h1000_0002)…; if_pc_plus4 = if_pc + 4.
- Backpressure: if_ready = 0 for 5 cycles after reset →
  - buffer fills with pc 0 and 4; instr_addr holds 8; if_pc holds 0.
  - When if_ready rises, outputs are 0, 4, 8 in consecutive cycles with no bubble.
- Redirect flush: while streaming at pc 12, pulse redirect_valid with target 32'h40 →
  - next cycle if_valid = 0, instr_addr = 32'h40.
  - cycle after: if_pc = 32'h40.
  - pc 12/16 entries never appear.
- Misaligned redirect plus simultaneous deq: target 32'h47 while if_valid = if_ready = 1 → the head transfer counts; next instr_addr = 32'h44; first output if_pc = 32'h44.
- PC wrap: redirect to 32'hFFFF_FFFC with if_ready = 1 → outputs if_pc 32'hFFFF_FFFC (if_pc_plus4 = 0), then if_pc 0.
- Async reset mid-run: assert reset_n = 0 between clock edges while full → if_valid = 0 and instr_addr = RESET_PC immediately; on release, streaming restarts at RESET_PC.
